// File: rtl/serialsub4_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serialsub4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 4;

endpackage

// File: rtl/serialsub4_fullsub.sv
// 1-bit gate-level full subtractor: d = x - y - bi, bo = borrow out.
module fullsub (
   output logic d,
   output logic bo,
   input  logic x,
   input  logic y,
   input  logic bi
);

   logic xy;
   logic nx;
   logic nxy;
   logic t_gen;
   logic t_prop;

   xor g_xy   (xy, x, y);
   xor g_d    (d, xy, bi);
   not g_nx   (nx, x);
   and g_gen  (t_gen, nx, y);
   not g_nxy  (nxy, xy);
   and g_prop (t_prop, nxy, bi);
   or  g_bo   (bo, t_gen, t_prop);

endmodule

// File: rtl/serialsub4.sv
// Bit-serial subtractor: a - b - b_in, one bit per clock LSB first, with start/done handshake.
module serialsub4
   import serialsub4_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
);

   localparam int unsigned    CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sd;
   logic             bor;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             bo_bit;
   logic [WIDTH-1:0] sd_next;

   fullsub u_fullsub (
      .d  (d_bit),
      .bo (bo_bit),
      .x  (sa[0]),
      .y  (sb[0]),
      .bi (bor)
   );

   // The current bit enters at the MSB so that after WIDTH shifts the LSB lands at bit 0.
   assign sd_next = {d_bit, sd[WIDTH-1:1]};

   // FSM, datapath shift registers and registered outputs in one clocked process.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         sa    <= '0;
         sb    <= '0;
         sd    <= '0;
         bor   <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         b_out <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  sd    <= '0;
                  bor   <= b_in;
                  cnt   <= '0;
                  state <= ST_RUN;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            ST_RUN: begin
               sa  <= {1'b0, sa[WIDTH-1:1]};
               sb  <= {1'b0, sb[WIDTH-1:1]};
               sd  <= sd_next;
               bor <= bo_bit;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  diff  <= sd_next;
                  b_out <= bo_bit;
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/serialsub4.md
# serialsub4

Bit-serial subtractor: computes `a - b - b_in` one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's ripple-carry adder, trading latency for area, with a start/done handshake so a controller or stimulus module can sequence it. The result and borrow-out are held stable in output registers between operations.

## Interface
- `WIDTH`, default 4: operand and result width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled on rising `clk`.
- `a`  in  WIDTH  minuend, captured on the accepting edge.
- `b`  in  WIDTH  subtrahend, captured on the accepting edge.
- `b_in`  in  1  borrow-in, captured on the accepting edge.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  single-cycle pulse: `diff`/`b_out` just updated.
- `diff`  out  WIDTH  result `(a - b - b_in) mod 2^WIDTH`.
- `b_out`  out  1  borrow-out: 1 iff `a < b + b_in` (unsigned).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, `start`=1: load `a`/`b` into shift registers `sa`/`sb`, set the borrow flop to `b_in`, clear the bit counter, and go to RUN. IDLE, `start`=0: stay in IDLE.
- Each RUN edge, in one step:
  - Full-subtractor on `sa[0]`, `sb[0]`, borrow: `d = sa0^sb0^bor`; `bor' = (~sa0 & sb0) | (~(sa0^sb0) & bor)`.
  - Shift `sa`/`sb` right by one.
  - Shift `d` into the MSB of the partial-result register `sd`, shifting `sd` right.
  - Increment the counter.
- On the WIDTH-th RUN edge, load `diff` with the final `sd` (including that edge's bit) and `b_out` with the final borrow, then go to DONE.
- DONE lasts exactly one cycle; `done`=1 for that cycle.
  - `start`=1 in DONE is accepted exactly as in IDLE (back-to-back), going to RUN.
  - Otherwise DONE goes to IDLE.
- `start` in RUN is ignored; operands on the bus are not sampled.
- `diff` and `b_out` change only on the final RUN edge. Partial results are never visible at the outputs.
- Reset (any time, including mid-RUN):
  - State goes to IDLE; `busy`=0, `done`=0, `diff`=0, `b_out`=0.
  - `sa`, `sb`, `sd`, borrow and counter are all cleared.
  - An in-flight operation is discarded with no `done`.
  - Outputs stay 0 until the next completed operation.
- Arithmetic is unsigned and modulo 2^WIDTH. `b_out` is the true borrow out of the MSB, with no sign or overflow interpretation. The counter is `$clog2(WIDTH+1)` bits wide.

## Timing
- Accepting edge E0 (`start`=1 in IDLE or DONE). `busy`=1 during the WIDTH cycles following E0 (the RUN edges E1..E_WIDTH).
- At E_WIDTH, `diff` and `b_out` update. `done`=1 and `busy`=0 for the cycle between E_WIDTH and E_WIDTH+1.
- Start-to-done latency: WIDTH+1 cycles from E0 to the falling edge of `done`. Throughput: one operation per WIDTH+1 cycles with back-to-back `start`.
- `busy` and `done` are registered state decodes and are never high together.
- Reset deassertion has no requirement beyond the async clear; the first accepting edge is the first rising `clk` with `rst_n`=1 and `start`=1.

## Structure
- Shared package/include: state encodings `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2, and the default `WIDTH`=4.
- One sub-module, `fullsub`: a 1-bit gate-level full subtractor (`d`, `bo`, `x`, `y`, `bi`), instantiated once.
- The top holds the FSM, counter, shift registers and output registers.

## Test plan
- `a`=7, `b`=3, `b_in`=0, `start` pulse → after 4 busy cycles, `done` pulse with `diff`=4'b0100 and `b_out`=0.
- `a`=3, `b`=4, `b_in`=0 → `diff`=4'b1111, `b_out`=1. Then `a`=0, `b`=0, `b_in`=1 → `diff`=4'b1111, `b_out`=1.
- `a`=10, `b`=5, `b_in`=1 → `diff`=4'b0100, `b_out`=0; `diff` holds 4'b0100 for 10 idle cycles afterwards.
- `start` held high with operands changed during RUN (`a`=9, `b`=4, then `a`=1 mid-run) → the first result is `diff`=4'b0101. The op is re-accepted in the DONE cycle with the bus values present then, and the next `done` follows exactly 5 cycles later.
- Assert `rst_n`=0 at the second RUN cycle of 15-1 → `busy`, `done`, `diff` and `b_out` are all 0 immediately and there is no `done` pulse. A subsequent 15-1 gives `diff`=4'b1110.
- Exhaustive sweep of all 512 combinations of `a`, `b`, `b_in` → every `{b_out,diff}` equals `{1'b0,a} - b - b_in` in 5 bits, and `busy`/`done` are never both high.
